// File: rtl/conv_pkg.sv
// Shared parameters, state encoding and result tag for the convolution window scheduler.
package conv_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int K          = 5;
  localparam int DW         = 32;
  localparam int CONV_LAT   = 1;
  localparam int CONV_RES_W = 69;
  localparam int COORD_W    = 5;

  // state  | meaning
  // IDLE   | waiting for start, no pixels accepted
  // RUN    | accepting pixels until the last pixel of the frame
  // DRAIN  | waiting for the final result to leave the latency pipeline
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // One stage of the latency pipeline that tags datapath results.
  typedef struct packed {
    logic               valid;
    logic               last;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } res_tag_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel history: a DEPTH-deep shift register advanced on each accepted pixel.
// dout is the value written DEPTH shifts ago, i.e. the same column one line earlier.
module conv_line_buffer #(
  parameter int DEPTH = 28,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  // Shift the line by one pixel; contents need no reset because a frame overwrites them before use.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_sched.sv
// Front-end for the 5x5 convolution datapath: takes a raster pixel stream, builds one KxK window per
// accepted pixel and tags the datapath's registered results with valid, coordinates and frame done.
module conv_window_sched #(
  parameter int IMG_W    = conv_pkg::IMG_W,
  parameter int IMG_H    = conv_pkg::IMG_H,
  parameter int K        = conv_pkg::K,
  parameter int DW       = conv_pkg::DW,
  parameter int CONV_LAT = conv_pkg::CONV_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [DW-1:0]                 pix_data,
  output logic [K*K*DW-1:0]             win_data,
  output logic                          win_valid,
  output logic                          res_valid,
  output logic [conv_pkg::COORD_W-1:0]  res_row,
  output logic [conv_pkg::COORD_W-1:0]  res_col
);

  import conv_pkg::*;

  sched_state_t state_q, state_d;

  logic [COORD_W-1:0] in_row, in_col;
  logic               accept;
  logic               last_pix;
  logic               win_done_now;

  // Row-major window: win_q[r][c], r = 0 is the oldest line, c = 0 the leftmost column.
  logic [K-1:0][K-1:0][DW-1:0] win_q;
  logic [DW-1:0]               col_in [K];
  logic [DW-1:0]               lb_out [K-1];

  logic               win_valid_q;
  logic               win_last_q;
  logic [COORD_W-1:0] win_row_q, win_col_q;

  res_tag_t tag_pipe [CONV_LAT];

  assign accept       = pix_valid && pix_ready;
  assign last_pix     = (in_row == COORD_W'(IMG_H-1)) && (in_col == COORD_W'(IMG_W-1));
  assign win_done_now = accept && (in_row >= COORD_W'(K-1)) && (in_col >= COORD_W'(K-1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; DRAIN ends on the cycle the last tagged result is presented.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    pix_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        pix_ready = 1'b1;
        if (accept && last_pix) state_d = DRAIN;
      end
      DRAIN: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel; cleared when a frame starts and after the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_row <= '0;
      in_col <= '0;
    end else if (state_q == IDLE && start) begin
      in_row <= '0;
      in_col <= '0;
    end else if (accept) begin
      if (in_col == COORD_W'(IMG_W-1)) begin
        in_col <= '0;
        in_row <= last_pix ? '0 : in_row + COORD_W'(1);
      end else begin
        in_col <= in_col + COORD_W'(1);
      end
    end
  end

  // Line buffer chain: the newest pixel enters buffer K-2 and each line ages down toward buffer 0.
  for (genvar k = 0; k < K-1; k++) begin : g_lb
    logic [DW-1:0] lb_in;
    if (k == K-2) begin : g_head
      assign lb_in = pix_data;
    end else begin : g_link
      assign lb_in = lb_out[k+1];
    end
    conv_line_buffer #(
      .DEPTH (IMG_W),
      .DW    (DW)
    ) u_lb (
      .clk  (clk),
      .en   (accept),
      .din  (lb_in),
      .dout (lb_out[k])
    );
    assign col_in[k] = lb_out[k];
  end
  assign col_in[K-1] = pix_data;

  // Slide the window one column left and load the new right column on every accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][K-1] <= col_in[r];
      end
    end
  end

  assign win_data  = win_q;
  assign win_valid = win_valid_q;

  // Mark the window complete and capture its output coordinates alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      win_valid_q <= win_done_now;
      win_last_q  <= win_done_now && last_pix;
      if (win_done_now) begin
        win_row_q <= in_row - COORD_W'(K-1);
        win_col_q <= in_col - COORD_W'(K-1);
      end
    end
  end

  // Delay the window tag by the datapath latency so it lines up with the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CONV_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: win_valid_q, last: win_last_q, row: win_row_q, col: win_col_q};
      for (int i = 1; i < CONV_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign res_valid = tag_pipe[CONV_LAT-1].valid;
  assign done      = tag_pipe[CONV_LAT-1].last;
  assign res_row   = tag_pipe[CONV_LAT-1].row;
  assign res_col   = tag_pipe[CONV_LAT-1].col;

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: control vectors from a table, then full frames with pixel value
// row*IMG_W+col, checked window-by-window and result-by-result against a reference model.
module tb_conv_window_sched;
  import conv_pkg::*;

  localparam int OW = IMG_W - K + 1;
  localparam int NW = (IMG_H - K + 1) * OW;
  localparam int NP = IMG_W * IMG_H;

  logic                clk = 1'b0;
  logic                rst, start, pix_valid;
  logic [DW-1:0]       pix_data;
  logic                busy, done, pix_ready, win_valid, res_valid;
  logic [K*K*DW-1:0]   win_data;
  logic [COORD_W-1:0]  res_row, res_col;

  int n_checks = 0;
  int n_err    = 0;

  conv_window_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .win_data  (win_data),
    .win_valid (win_valid),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_col   (res_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int   win_idx = 0;
  int   res_idx = 0;
  logic prev_wv = 1'b0;
  logic prev_acc = 1'b0;
  logic prev_rst = 1'b1;

  always @(negedge clk) begin
    logic [K*K*DW-1:0] ew;
    if (prev_rst == 1'b0) begin
      if (win_valid) chk("win_after_accept", prev_acc, 1);
      chk("res_trails_win", res_valid, prev_wv);
      if (win_valid) begin
        if (win_idx < NW) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              ew[(r*K+c)*DW +: DW] = DW'((win_idx/OW + r)*IMG_W + (win_idx%OW + c));
          n_checks++;
          if (win_data !== ew) begin
            n_err++;
            $display("FAIL window[%0d]: got e0=%0d e24=%0d, expected e0=%0d e24=%0d", win_idx,
                     win_data[0 +: DW], win_data[(K*K-1)*DW +: DW], ew[0 +: DW], ew[(K*K-1)*DW +: DW]);
          end
        end else begin
          chk("extra_window", win_idx, NW - 1);
        end
        win_idx++;
      end
      if (res_valid) begin
        chk($sformatf("res_row[%0d]", res_idx), res_row, res_idx / OW);
        chk($sformatf("res_col[%0d]", res_idx), res_col, res_idx % OW);
        chk($sformatf("done[%0d]", res_idx), done, (res_idx == NW-1) ? 1 : 0);
        res_idx++;
      end else if (done) begin
        chk("done_without_res", done, 0);
      end
    end
    if (rst || (start && !busy)) begin
      win_idx = 0;
      res_idx = 0;
    end
    prev_wv  = win_valid;
    prev_acc = pix_valid && pix_ready;
    prev_rst = rst;
  end

  // Run one frame; abort_at >= 0 replaces that pixel with a reset pulse and returns.
  task automatic send_frame(input bit gaps, input int abort_at);
    int p = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", pix_ready, 1);
    while (p < NP) begin
      if (p == abort_at) begin
        rst = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", pix_ready, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_res_col", res_col, 0);
        chk("rst_win_data_zero", (win_data == '0) ? 1 : 0, 1);
        return;
      end
      chk("ready_in_run", pix_ready, 1);
      start = (p == 100);
      if (gaps && $urandom_range(1, 0) == 0) begin
        pix_valid = 1'b0;
        pix_data  = $urandom;
      end else begin
        pix_valid = 1'b1;
        pix_data  = DW'(p);
        p++;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    start = 1'b1;
    chk("last_win_valid", win_valid, 1);
    chk("drain_busy", busy, 1);
    chk("drain_ready", pix_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_res_row", res_row, IMG_H - K);
    chk("done_res_col", res_col, IMG_W - K);
    chk("done_busy", busy, 1);
    @(posedge clk); #1;
    chk("busy_fall", busy, 0);
    chk("done_single", done, 0);
    chk("win_count", win_idx, NW);
    chk("res_count", res_idx, NW);
  endtask

  typedef struct {
    logic rst, start, pv;
    logic busy, ready, wv, rv;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{rst:1, start:0, pv:0, busy:0, ready:0, wv:0, rv:0};
    vecs[1] = '{rst:0, start:0, pv:1, busy:0, ready:0, wv:0, rv:0};
    vecs[2] = '{rst:0, start:0, pv:1, busy:0, ready:0, wv:0, rv:0};
    vecs[3] = '{rst:0, start:1, pv:0, busy:1, ready:1, wv:0, rv:0};
    vecs[4] = '{rst:0, start:0, pv:1, busy:1, ready:1, wv:0, rv:0};
    vecs[5] = '{rst:0, start:1, pv:1, busy:1, ready:1, wv:0, rv:0};
    vecs[6] = '{rst:1, start:0, pv:0, busy:0, ready:0, wv:0, rv:0};
    vecs[7] = '{rst:0, start:1, pv:1, busy:1, ready:1, wv:0, rv:0};
    vecs[8] = '{rst:1, start:0, pv:0, busy:0, ready:0, wv:0, rv:0};

    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      rst       = vecs[i].rst;
      start     = vecs[i].start;
      pix_valid = vecs[i].pv;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_ready", i), pix_ready, vecs[i].ready);
      chk($sformatf("vec%0d_win_valid", i), win_valid, vecs[i].wv);
      chk($sformatf("vec%0d_res_valid", i), res_valid, vecs[i].rv);
      if (i == 0) begin
        chk("reset_done", done, 0);
        chk("reset_res_row", res_row, 0);
        chk("reset_res_col", res_col, 0);
        chk("reset_win_data_zero", (win_data == '0) ? 1 : 0, 1);
      end
    end
    rst = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1;

    send_frame(1'b0, -1);
    send_frame(1'b1, -1);
    send_frame(1'b0, 10*IMG_W + 15);
    send_frame(1'b0, -1);
    send_frame(1'b0, -1);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Sequencing front-end for the 5x5, 8-filter convolution datapath. Accepts a 28x28 image streamed in raster order and keeps four line buffers plus a 5x5 window register. Presents one complete window per accepted pixel on the datapath's 25 `data_rc` inputs. Tracks the datapath's fixed latency so every registered convolution result is tagged with a valid strobe, output coordinates, and an end-of-frame done pulse.

## Interface
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `K`, 5: kernel size.
- `DW`, 32: pixel width, signed.
- `CONV_LAT`, 1: cycles from window presentation to the datapath's registered result.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset `rst`, synchronous, active-high; clock `clk`.
- `start`, in, 1: one-cycle frame start request, sampled only in IDLE.
- `busy`, out, 1: high whenever state != IDLE.
- `done`, out, 1: one-cycle pulse coincident with the final `res_valid` of a frame.
- `pix_valid`, in, 1: pixel offered.
- `pix_ready`, out, 1: high only in RUN.
- `pix_data`, in, DW: pixel value.
- `win_data`, out, K*K*DW: window flattened row-major. Element r*K+c occupies bits [(r*K+c)*DW +: DW] and drives datapath `data_rc` (r = row from top, c = column from left).
- `win_valid`, out, 1: `win_data` holds a complete window this cycle.
- `res_valid`, out, 1: datapath outputs hold a valid result this cycle.
- `res_row`, `res_col`, out, 5 each: output coordinates 0..IMG_H-K and 0..IMG_W-K for the current result.

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: the last pixel (row IMG_H-1, col IMG_W-1) is accepted → DRAIN.
  - DRAIN: after the final `res_valid` cycle → IDLE.
- Accept condition: `pix_valid && pix_ready`. Nothing changes on cycles without an accept, except the DRAIN/latency pipeline, which runs freely.
- Input counters `in_row`, `in_col`:
  - Cleared on entering RUN.
  - `in_col` wraps IMG_W-1 → 0 and increments `in_row`.
- Each accept:
  - Shift every window row one column left.
  - Insert the new right column: rows 0..3 from line buffers 0..3 at `in_col`; row 4 = `pix_data`.
  - Line buffer k takes the value leaving buffer k+1; buffer 3 takes `pix_data`.
- Window complete when an accept happens at `in_row >= K-1 && in_col >= K-1`. `win_valid` is registered from this condition, and the window coordinates are registered with it.
- Window coordinates are in_row-(K-1) and in_col-(K-1). They are delayed CONV_LAT cycles alongside `win_valid` to form `res_valid`, `res_row`, `res_col`.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1) = 576 with defaults. Columns 0..3 of each row prime the window and produce no `win_valid`.
- `start` while busy: ignored. `pix_valid` while not RUN: not accepted, no state change.
- Window values pass through unmodified. There is no arithmetic on data.

## Timing
- `start` sampled high in IDLE at cycle 0 → `busy` and `pix_ready` high from cycle 1.
- Pixel accepted at cycle t, window complete → `win_valid` at t+1, `res_valid` at t+1+CONV_LAT.
- Last pixel accepted at cycle L → `done` at L+1+CONV_LAT, together with `res_row` = `res_col` = 23. `busy` is low from L+2+CONV_LAT.
- Maximum throughput: one pixel per cycle, so a gap-free frame runs 784 accept cycles.
- Reset (any state, including mid-frame):
  - Next cycle: IDLE; `busy`, `done`, `pix_ready`, `win_valid`, `res_valid` = 0; `res_row`, `res_col`, `win_data` = 0; counters = 0; pipeline flushed.
  - Line buffer contents are don't-care.
- Results in flight at reset are discarded.

## Structure
- Package `conv_pkg`:
  - `IMG_W`, `IMG_H`, `K`, `DW`, `CONV_LAT` defaults.
  - `CONV_RES_W` = 69.
  - State enum `sched_state_t` {IDLE, RUN, DRAIN}.
- Sub-module `conv_line_buffer`: IMG_W-deep, DW-wide shift buffer with shift-enable, instantiated four times.
- The CONV_LAT delay line for valid and coordinates lives in this block.

## Test plan
- Gap-free frame, pix = row*28+col:
  - First `win_valid` the cycle after pixel (4,4) is accepted, with element 0 = 0 and element 24 = 116.
  - Exactly 576 `win_valid`.
  - Last window element 0 = 667.
- Random `pix_valid` gaps (50%): identical window sequence and count. `win_valid` only ever follows an accept by one cycle.
- Result tagging: `res_valid` trails `win_valid` by CONV_LAT. Coordinates run (0,0)…(0,23),(1,0)…(23,23); `done` is a single pulse with the (23,23) result.
- `start` pulsed during RUN and DRAIN → ignored. `pix_valid` high in IDLE → `pix_ready` = 0, no window produced.
- `rst` asserted at pixel (10,15):
  - All outputs 0 next cycle.
  - A new `start` and a full frame give a correct first window and 576 windows.
- Back-to-back frames: `start` the cycle `busy` falls → second frame matches the first exactly.
